// File: rtl/vga_stream_gen.sv
// -----------------------------------------------------------------------------
// vga_stream_gen
//
// Purpose:
//   VGA raster timing generator. Walks a horizontal counter (hc) across every
//   pixel slot of a line, including blanking, and a vertical counter (vc)
//   across every line of a frame. Each enabled pixel-clock edge produces one
//   pixel position plus its decoded activevideo/hsync/vsync flags. All flags
//   and coordinates are registered together, so they always describe the same
//   pixel.
//
// Ports:
//   px_clk     in   1   pixel clock, the only clock
//   reset      in   1   asynchronous, active-high reset
//   px_en      in   1   pixel advance enable; counters move only when 1
//   strVGA     out  23  {activevideo, hsync, vsync, x[9:0], y[9:0]}
//   endframe   out  1   one-cycle pulse after the last active pixel of a frame
//   frame_cnt  out  8   frames completed since reset, modulo 256
//
// Parameters:
//   H_ACTIVE/H_FP/H_SYNC/H_BP  horizontal timing in pixels
//   V_ACTIVE/V_FP/V_SYNC/V_BP  vertical timing in lines
//   SYNC_POL                   asserted sync level (0 = active-low)
//   Both line and frame totals must be at most 1024 so that the 10-bit
//   counters never overflow.
// -----------------------------------------------------------------------------
module vga_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        px_clk,
  input  logic        reset,
  input  logic        px_en,
  output logic [22:0] strVGA,
  output logic        endframe,
  output logic [7:0]  frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync window bounds, half-open: [start, end)
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  // Terminal counts, sized to the counter width
  localparam logic [9:0] HC_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] VC_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HA_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] VA_LAST = 10'(V_ACTIVE - 1);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = ~SYNC_ON;

  // ---------------------------------------------------------------------------
  // Decode helpers. Counters are zero-extended before comparison so that
  // window bounds equal to 1024 (sync running to the end of the line) are
  // still compared correctly.
  // ---------------------------------------------------------------------------
  function automatic logic active_at(input logic [9:0] h, input logic [9:0] v);
    logic [31:0] h32;
    logic [31:0] v32;
    h32 = {22'd0, h};
    v32 = {22'd0, v};
    return (h32 < 32'(H_ACTIVE)) && (v32 < 32'(V_ACTIVE));
  endfunction

  function automatic logic hsync_at(input logic [9:0] h);
    logic [31:0] h32;
    h32 = {22'd0, h};
    return ((h32 >= 32'(HS_START)) && (h32 < 32'(HS_END))) ? SYNC_ON : SYNC_OFF;
  endfunction

  function automatic logic vsync_at(input logic [9:0] v);
    logic [31:0] v32;
    v32 = {22'd0, v};
    return ((v32 >= 32'(VS_START)) && (v32 < 32'(VS_END))) ? SYNC_ON : SYNC_OFF;
  endfunction

  // Registered raster state (single output stage)
  logic [9:0] hc_p0;
  logic [9:0] vc_p0;
  logic       active_p0;
  logic       hsync_p0;
  logic       vsync_p0;
  logic       endframe_p0;
  logic [7:0] frame_cnt_p0;

  // Next-position logic
  logic [9:0] hc_next;
  logic [9:0] vc_next;
  logic       hc_wrap;
  logic       vc_wrap;
  logic       frame_wrap;
  logic       last_active;

  always_comb begin
    hc_wrap     = (hc_p0 == HC_LAST);
    vc_wrap     = (vc_p0 == VC_LAST);
    frame_wrap  = hc_wrap && vc_wrap;
    // The edge leaving the final visible pixel of the frame marks endframe.
    last_active = (hc_p0 == HA_LAST) && (vc_p0 == VA_LAST);

    hc_next = hc_wrap ? 10'd0 : (hc_p0 + 10'd1);
    vc_next = vc_p0;
    if (hc_wrap) begin
      vc_next = vc_wrap ? 10'd0 : (vc_p0 + 10'd1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0: counters and flags registered together. Flags are decoded from
  // the next counter values so they line up with the coordinates they sit
  // beside. With px_en low everything holds except endframe, which clears so
  // a stall never stretches or repeats the pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      hc_p0        <= 10'd0;
      vc_p0        <= 10'd0;
      active_p0    <= 1'b1;
      hsync_p0     <= SYNC_OFF;
      vsync_p0     <= SYNC_OFF;
      endframe_p0  <= 1'b0;
      frame_cnt_p0 <= 8'd0;
    end else if (px_en) begin
      hc_p0       <= hc_next;
      vc_p0       <= vc_next;
      active_p0   <= active_at(hc_next, vc_next);
      hsync_p0    <= hsync_at(hc_next);
      vsync_p0    <= vsync_at(vc_next);
      endframe_p0 <= last_active;
      if (frame_wrap) begin
        frame_cnt_p0 <= frame_cnt_p0 + 8'd1;
      end
    end else begin
      endframe_p0 <= 1'b0;
    end
  end

  assign strVGA    = {active_p0, hsync_p0, vsync_p0, hc_p0, vc_p0};
  assign endframe  = endframe_p0;
  assign frame_cnt = frame_cnt_p0;

endmodule
